// File: rtl/aemb_pkg.sv
// Shared constants and types for the AEMB instruction prefetch buffer.
// Opcode groups that must not be split from their successor by an interrupt.
package aemb_pkg;

  localparam logic [5:0] OPC_IMM  = 6'o54;
  localparam logic [5:0] OPC_RTD  = 6'o55;
  localparam logic [5:0] OPC_BRU  = 6'o46;
  localparam logic [5:0] OPC_BRUI = 6'o56;
  localparam logic [5:0] OPC_BCC  = 6'o47;
  localparam logic [5:0] OPC_BCCI = 6'o57;

  localparam logic [31:0] INTOP_DEF = 32'hB9CE0010;
  localparam logic [31:0] BRAOP_DEF = 32'h88000000;

  typedef enum logic [1:0] {
    F_IDLE,
    F_REQ,
    F_DROP
  } fetch_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  function automatic logic int_blocked(input logic [5:0] op);
    return (op == OPC_IMM)  || (op == OPC_RTD) ||
           (op == OPC_BRU)  || (op == OPC_BRUI) ||
           (op == OPC_BCC)  || (op == OPC_BCCI);
  endfunction

endpackage

// File: rtl/aemb_ififo_if.sv
// Wishbone instruction-fetch port of the prefetch buffer.
// The fetch engine is master; the instruction memory is slave.
interface aemb_ififo_if #(
  parameter int AW = 32
) ();

  logic [AW-1:0] iwb_adr_o;
  logic          iwb_stb_o;
  logic [31:0]   iwb_dat_i;
  logic          iwb_ack_i;

  modport master (
    output iwb_adr_o,
    output iwb_stb_o,
    input  iwb_dat_i,
    input  iwb_ack_i
  );

  modport slave (
    input  iwb_adr_o,
    input  iwb_stb_o,
    output iwb_dat_i,
    output iwb_ack_i
  );

endinterface

// File: rtl/aemb_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers and synchronous clear.
// Clear wins over a same-cycle push or pop.
module aemb_sync_fifo
  import aemb_pkg::*;
#(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int PW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [PW:0]      level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW:0]      wptr_q, wptr_d;
  logic [PW:0]      rptr_q, rptr_d;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (clr) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr) mem_q[wptr_q[PW-1:0]] <= din;
  end

  assign dout  = mem_q[rptr_q[PW-1:0]];
  assign level = wptr_q - rptr_q;
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PW-1:0] == rptr_q[PW-1:0]) &&
                 (wptr_q[PW] != rptr_q[PW]);

endmodule

// File: rtl/aemb_ififo.sv
// AEMB instruction prefetch buffer: Wishbone fetch engine, FIFO,
// decode register with branch flush, IMM merging and interrupt injection.
module aemb_ififo
  import aemb_pkg::*;
#(
  parameter  int            DEPTH  = 4,
  parameter  int            AW     = 32,
  parameter  logic [AW-1:0] RST_PC = '0,
  parameter  logic [31:0]   INTOP  = INTOP_DEF,
  parameter  logic [31:0]   BRAOP  = BRAOP_DEF,
  localparam int            LW     = clog2(DEPTH) + 1
) (
  input  logic          gclk,
  input  logic          grst,
  input  logic          gena,
  input  logic          rBRA,
  input  logic [AW-1:0] rBTGT,
  input  logic          rMSR_IE,
  input  logic          sys_int_i,
  aemb_ififo_if.master  iwb,
  output logic [5:0]    rOPC,
  output logic [4:0]    rRD,
  output logic [4:0]    rRA,
  output logic [15:0]   rIMM,
  output logic [4:0]    rRB,
  output logic [10:0]   rALT,
  output logic [31:0]   rSIMM,
  output logic [AW-1:0] rPC,
  output logic          rVLD,
  output logic [LW-1:0] rLVL
);

  fetch_state_e  st_q, st_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [AW-1:0] tgt_q, tgt_d;
  logic [31:0]   ir_q, ir_d;
  logic [31:0]   simm_q, simm_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          vld_q, vld_d;
  logic          int_q, int_d;
  logic          prev_q;

  logic [AW+31:0] head;
  logic [LW-1:0]  lvl, lvl_nxt;
  logic           full, empty;
  logic           flush, push, pop, take, ack;
  logic [AW-1:0]  bt, fadr;
  logic [31:0]    newi;
  logic           merge;

  assign ack   = iwb.iwb_ack_i;
  assign bt    = rBTGT & ~AW'(3);
  assign flush = gena & rBRA;
  assign take  = gena & ~rBRA & int_q & ~int_blocked(ir_q[31:26]);
  assign pop   = gena & ~rBRA & ~take & ~empty;
  assign push  = ack & (st_q == F_REQ) & ~flush & ~full;
  assign fadr  = (st_q == F_DROP) ? tgt_q : adr_q;

  assign lvl_nxt = flush ? '0 : lvl + LW'(push) - LW'(pop);

  aemb_sync_fifo #(
    .WIDTH (AW + 32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (gclk),
    .rst   (grst),
    .push  (push),
    .pop   (pop),
    .clr   (flush),
    .din   ({adr_q, iwb.iwb_dat_i}),
    .dout  (head),
    .level (lvl),
    .full  (full),
    .empty (empty)
  );

  // an ack arriving in DROP belongs to a flushed stream and is discarded
  always_comb begin
    st_d  = st_q;
    adr_d = adr_q;
    tgt_d = tgt_q;
    unique case (st_q)
      F_IDLE: begin
        if (flush) adr_d = bt;
        if (lvl_nxt < LW'(DEPTH)) st_d = F_REQ;
      end
      F_REQ: begin
        if (ack) begin
          adr_d = flush ? bt : adr_q + AW'(4);
          st_d  = (lvl_nxt < LW'(DEPTH)) ? F_REQ : F_IDLE;
        end else if (flush) begin
          tgt_d = bt;
          st_d  = F_DROP;
        end
      end
      F_DROP: begin
        if (ack) begin
          adr_d = flush ? bt : tgt_q;
          st_d  = F_REQ;
        end else if (flush) begin
          tgt_d = bt;
        end
      end
      default: st_d = F_IDLE;
    endcase
  end

  always_comb begin
    ir_d   = ir_q;
    simm_d = simm_q;
    pc_d   = pc_q;
    vld_d  = vld_q;
    int_d  = int_q;
    newi   = BRAOP;
    merge  = 1'b0;
    if (gena) begin
      if (rBRA) begin
        vld_d = 1'b0;
      end else if (take) begin
        newi  = INTOP;
        pc_d  = empty ? fadr : head[AW+31:32];
        vld_d = 1'b1;
      end else if (!empty) begin
        newi  = head[31:0];
        pc_d  = head[AW+31:32];
        vld_d = 1'b1;
        merge = (ir_q[31:26] == OPC_IMM);
      end else begin
        vld_d = 1'b0;
      end
      ir_d   = newi;
      simm_d = merge ? {ir_q[15:0], newi[15:0]}
                     : {{16{newi[15]}}, newi[15:0]};
    end
    if (take)
      int_d = 1'b0;
    else if (rMSR_IE && sys_int_i && !prev_q)
      int_d = 1'b1;
  end

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      st_q   <= F_IDLE;
      adr_q  <= RST_PC;
      tgt_q  <= RST_PC;
      ir_q   <= '0;
      simm_q <= '0;
      pc_q   <= '0;
      vld_q  <= 1'b0;
      int_q  <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      adr_q  <= adr_d;
      tgt_q  <= tgt_d;
      ir_q   <= ir_d;
      simm_q <= simm_d;
      pc_q   <= pc_d;
      vld_q  <= vld_d;
      int_q  <= int_d;
      prev_q <= sys_int_i;
    end
  end

  assign iwb.iwb_adr_o = adr_q;
  assign iwb.iwb_stb_o = (st_q != F_IDLE);

  assign rOPC  = ir_q[31:26];
  assign rRD   = ir_q[25:21];
  assign rRA   = ir_q[20:16];
  assign rIMM  = ir_q[15:0];
  assign rRB   = ir_q[15:11];
  assign rALT  = ir_q[10:0];
  assign rSIMM = simm_q;
  assign rPC   = pc_q;
  assign rVLD  = vld_q;
  assign rLVL  = lvl;

endmodule
